// File: rtl/mips_bus_arbiter.sv
// Two-master arbiter for the external memory bus: per-transaction grant,
// grant locked through slave stalls, read return routed back to its issuer.
module mips_bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic [ADDR_WIDTH-1:0]   m0_address,
    input  logic                    m0_read,
    input  logic                    m0_write,
    input  logic [DATA_WIDTH-1:0]   m0_writedata,
    input  logic [DATA_WIDTH/8-1:0] m0_byteenable,
    output logic                    m0_waitrequest,
    output logic [DATA_WIDTH-1:0]   m0_readdata,
    output logic                    m0_readdatavalid,

    input  logic [ADDR_WIDTH-1:0]   m1_address,
    input  logic                    m1_read,
    input  logic                    m1_write,
    input  logic [DATA_WIDTH-1:0]   m1_writedata,
    input  logic [DATA_WIDTH/8-1:0] m1_byteenable,
    output logic                    m1_waitrequest,
    output logic [DATA_WIDTH-1:0]   m1_readdata,
    output logic                    m1_readdatavalid,

    output logic [ADDR_WIDTH-1:0]   s_address,
    output logic                    s_read,
    output logic                    s_write,
    output logic [DATA_WIDTH-1:0]   s_writedata,
    output logic [DATA_WIDTH/8-1:0] s_byteenable,
    input  logic                    s_waitrequest,
    input  logic [DATA_WIDTH-1:0]   s_readdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        RDATA = 2'd2
    } state_t;

    state_t state_reg;
    logic   owner_reg;
    logic   last_grant_reg;

    logic [ADDR_WIDTH-1:0]   addr  [2];
    logic [DATA_WIDTH-1:0]   wdata [2];
    logic [DATA_WIDTH/8-1:0] be    [2];
    logic [1:0]              rd_req;
    logic [1:0]              wr_req;
    logic [1:0]              req;
    logic [1:0]              wait_vec;
    logic [1:0]              rdv_vec;

    logic sel;
    logic active;
    logic accept;

    assign addr[0]  = m0_address;
    assign addr[1]  = m1_address;
    assign wdata[0] = m0_writedata;
    assign wdata[1] = m1_writedata;
    assign be[0]    = m0_byteenable;
    assign be[1]    = m1_byteenable;
    assign rd_req   = {m1_read,  m0_read};
    assign wr_req   = {m1_write, m0_write};
    assign req      = rd_req | wr_req;

    // sel picks the master driving the slave; active means that master has a live request
    always_comb begin
        sel    = owner_reg;
        active = 1'b0;
        case (state_reg)
            IDLE: begin
                active = |req;
                if (req == 2'b10)
                    sel = 1'b1;
                else if (req == 2'b01)
                    sel = 1'b0;
                else
                    sel = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant_reg;
            end
            HOLD: begin
                sel    = owner_reg;
                active = req[owner_reg];
            end
            default: begin
                sel    = owner_reg;
                active = 1'b0;
            end
        endcase
        if (reset)
            active = 1'b0;
    end

    assign accept = active & ~s_waitrequest;

    // A simultaneous read+write is issued as a write only
    assign s_address    = addr[sel];
    assign s_writedata  = wdata[sel];
    assign s_byteenable = be[sel];
    assign s_write      = active & wr_req[sel];
    assign s_read       = active & rd_req[sel] & ~wr_req[sel];

    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        assign wait_vec[gi] = ~(accept && (sel == 1'(gi)));
        assign rdv_vec[gi]  = (state_reg == RDATA) && (owner_reg == 1'(gi)) && !reset;
    end

    assign m0_waitrequest   = wait_vec[0];
    assign m1_waitrequest   = wait_vec[1];
    assign m0_readdatavalid = rdv_vec[0];
    assign m1_readdatavalid = rdv_vec[1];
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
        end else begin
            case (state_reg)
                IDLE, HOLD: begin
                    if (!active) begin
                        state_reg <= IDLE;
                    end else begin
                        owner_reg <= sel;
                        if (s_waitrequest) begin
                            state_reg <= HOLD;
                        end else begin
                            last_grant_reg <= sel;
                            state_reg      <= wr_req[sel] ? IDLE : RDATA;
                        end
                    end
                end
                RDATA:   state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Scoreboard bench for mips_bus_arbiter: one round-robin and one fixed-priority
// instance, random masters and a random-stall memory, checked against a reference model.
`timescale 1ns/1ps
module tb_mips_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   load_pct;
    int   stall_pct;
    bit   script_go;
    bit   draining;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } txn_t;

    typedef struct {
        int          drv;
        bit          acc;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } cyc_t;

    localparam int SCRIPT_LEN = 2;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_1E0F;
    endfunction

    function automatic txn_t script_txn(input int m, input int k);
        txn_t t;
        t.rd = 1'b0; t.wr = 1'b0; t.addr = 32'h0; t.data = 32'h0; t.be = 4'hF;
        if (m == 0) begin
            if (k == 0) begin
                t.rd = 1'b1; t.wr = 1'b1; t.addr = 32'hBFC0_0000; t.data = 32'h1234_5678;
            end else begin
                t.rd = 1'b1; t.addr = 32'hBFC0_0004;
            end
        end else begin
            if (k == 0) begin
                t.wr = 1'b1; t.addr = 32'hBFC0_0100; t.data = 32'hDEAD_BEEF; t.be = 4'b0011;
            end else begin
                t.rd = 1'b1; t.addr = 32'hBFC0_0100;
            end
        end
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam bit FIXED = (gi == 1);

        logic [1:0][31:0] m_addr, m_wdata, m_rdata;
        logic [1:0][3:0]  m_be;
        logic [1:0]       m_read, m_write, m_wait, m_rdv;
        logic [31:0]      s_addr, s_wdata, s_rdata;
        logic [3:0]       s_be;
        logic             s_read, s_write, s_wait;

        mips_bus_arbiter #(
            .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIORITY(gi)
        ) dut (
            .clk(clk), .reset(reset),
            .m0_address(m_addr[0]), .m0_read(m_read[0]), .m0_write(m_write[0]),
            .m0_writedata(m_wdata[0]), .m0_byteenable(m_be[0]),
            .m0_waitrequest(m_wait[0]), .m0_readdata(m_rdata[0]), .m0_readdatavalid(m_rdv[0]),
            .m1_address(m_addr[1]), .m1_read(m_read[1]), .m1_write(m_write[1]),
            .m1_writedata(m_wdata[1]), .m1_byteenable(m_be[1]),
            .m1_waitrequest(m_wait[1]), .m1_readdata(m_rdata[1]), .m1_readdatavalid(m_rdv[1]),
            .s_address(s_addr), .s_read(s_read), .s_write(s_write),
            .s_writedata(s_wdata), .s_byteenable(s_be),
            .s_waitrequest(s_wait), .s_readdata(s_rdata)
        );

        txn_t        cur [2];
        bit          busy [2];
        bit          acc [2];
        int          sidx [2];
        cyc_t        exp_cyc [$];
        logic [31:0] exp_rd [2][$];
        bit          ret_pending;
        int          prefer;
        int          locked;
        bit          rd_acc;
        logic [31:0] rd_addr;

        // Masters: hold each request until accepted, then maybe start another
        initial begin
            m_read = '0; m_write = '0; m_addr = '0; m_wdata = '0; m_be = '0;
            busy = '{0, 0}; sidx = '{0, 0};
            forever begin
                @(negedge clk);
                for (int j = 0; j < 2; j++)
                    acc[j] = !reset && (m_read[j] || m_write[j]) && !m_wait[j];
                @(posedge clk);
                #1;
                for (int j = 0; j < 2; j++) begin
                    if (acc[j]) busy[j] = 1'b0;
                    if (!busy[j] && $urandom_range(0, 99) < load_pct) begin
                        if (script_go && sidx[j] < SCRIPT_LEN) begin
                            cur[j] = script_txn(j, sidx[j]);
                            sidx[j]++;
                        end else begin
                            int k;
                            k = $urandom_range(0, 9);
                            cur[j].rd   = (k <= 5);
                            cur[j].wr   = (k >= 5);
                            cur[j].addr = $urandom & 32'hFFFF_FFFC;
                            cur[j].data = $urandom;
                            cur[j].be   = 4'($urandom_range(1, 15));
                        end
                        busy[j] = 1'b1;
                    end
                    m_read[j]  = busy[j] && cur[j].rd;
                    m_write[j] = busy[j] && cur[j].wr;
                    m_addr[j]  = cur[j].addr;
                    m_wdata[j] = cur[j].data;
                    m_be[j]    = cur[j].be;
                end
            end
        end

        // Memory: random stalls; read data returned the cycle after acceptance
        initial begin
            s_wait = 1'b0;
            s_rdata = '0;
            forever begin
                @(negedge clk);
                rd_acc  = !reset && s_read && !s_wait;
                rd_addr = s_addr;
                @(posedge clk);
                #1;
                s_rdata = rd_acc ? mem_data(rd_addr) : $urandom;
                s_wait  = ($urandom_range(0, 99) < stall_pct);
            end
        end

        // Reference model: predicts, per cycle, who drives the bus and who is accepted
        initial begin
            locked = -1; prefer = 0; ret_pending = 1'b0;
            forever begin
                @(negedge clk);
                if (reset) begin
                    locked = -1; prefer = 0; ret_pending = 1'b0;
                    exp_rd[0].delete();
                    exp_rd[1].delete();
                    exp_cyc.delete();
                end else begin
                    cyc_t e;
                    bit [1:0] want;
                    e.drv = -1; e.acc = 0; e.rd = 0; e.wr = 0;
                    e.addr = '0; e.data = '0; e.be = '0;
                    want = m_read | m_write;
                    if (ret_pending) begin
                        ret_pending = 1'b0;
                    end else begin
                        if (locked >= 0)
                            e.drv = want[locked] ? locked : -1;
                        else if (want == 2'b11)
                            e.drv = FIXED ? 0 : prefer;
                        else if (want[0])
                            e.drv = 0;
                        else if (want[1])
                            e.drv = 1;
                        locked = -1;
                        if (e.drv >= 0) begin
                            e.wr   = m_write[e.drv];
                            e.rd   = m_read[e.drv] && !m_write[e.drv];
                            e.addr = m_addr[e.drv];
                            e.data = m_wdata[e.drv];
                            e.be   = m_be[e.drv];
                            if (s_wait) begin
                                locked = e.drv;
                            end else begin
                                e.acc  = 1'b1;
                                prefer = 1 - e.drv;
                                if (e.rd) begin
                                    exp_rd[e.drv].push_back(mem_data(e.addr));
                                    ret_pending = 1'b1;
                                end
                            end
                        end
                    end
                    exp_cyc.push_back(e);
                end
            end
        end

        // Monitor: pops predictions and compares against what the DUT presents
        initial begin
            forever begin
                @(negedge clk);
                #1;
                if (reset) begin
                    check($sformatf("i%0d_rst_s_read", gi), 32'(s_read), 32'd0);
                    check($sformatf("i%0d_rst_s_write", gi), 32'(s_write), 32'd0);
                    check($sformatf("i%0d_rst_wait", gi), 32'(m_wait), 32'd3);
                    check($sformatf("i%0d_rst_rdv", gi), 32'(m_rdv), 32'd0);
                end else begin
                    if (exp_cyc.size() == 0) begin
                        fail_now($sformatf("i%0d_cycle", gi), "no prediction available");
                    end else begin
                        cyc_t e;
                        logic [1:0] exp_wait;
                        e = exp_cyc.pop_front();
                        exp_wait = 2'b11;
                        if (e.acc) exp_wait[e.drv] = 1'b0;
                        check($sformatf("i%0d_waitrequest", gi), 32'(m_wait), 32'(exp_wait));
                        check($sformatf("i%0d_s_read", gi), 32'(s_read), 32'(e.rd));
                        check($sformatf("i%0d_s_write", gi), 32'(s_write), 32'(e.wr));
                        if (e.rd || e.wr)
                            check($sformatf("i%0d_s_address", gi), s_addr, e.addr);
                        if (e.wr) begin
                            check($sformatf("i%0d_s_writedata", gi), s_wdata, e.data);
                            check($sformatf("i%0d_s_byteenable", gi), 32'(s_be), 32'(e.be));
                        end
                        if (e.acc)
                            $display("[%0t] inst%0d m%0d %s addr=%h data=%h be=%h", $time, gi,
                                     e.drv, e.wr ? "write" : "read", e.addr, e.data, e.be);
                    end
                    for (int j = 0; j < 2; j++) begin
                        if (m_rdv[j]) begin
                            if (exp_rd[j].size() == 0)
                                fail_now($sformatf("i%0d_m%0d_readdatavalid", gi, j),
                                         "pulse with no read outstanding");
                            else
                                check($sformatf("i%0d_m%0d_readdata", gi, j),
                                      m_rdata[j], exp_rd[j].pop_front());
                        end
                    end
                end
            end
        end

        initial begin
            wait (draining);
            check($sformatf("i%0d_m0_reads_unreturned", gi), 32'(exp_rd[0].size()), 32'd0);
            check($sformatf("i%0d_m1_reads_unreturned", gi), 32'(exp_rd[1].size()), 32'd0);
            check($sformatf("i%0d_m0_unserved", gi), 32'(busy[0]), 32'd0);
            check($sformatf("i%0d_m1_unserved", gi), 32'(busy[1]), 32'd0);
        end
    end

    initial begin
        reset     = 1'b1;
        load_pct  = 100;
        stall_pct = 0;
        script_go = 1'b0;
        draining  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Both masters streaming, no stalls
        repeat (40) @(posedge clk);

        // Random traffic with stalls, plus the scripted boundary transactions
        load_pct  = 60;
        stall_pct = 30;
        script_go = 1'b1;
        repeat (300) @(posedge clk);

        // Reset landing in a read-return cycle
        for (int r = 0; r < 3; r++) begin
            int n;
            bit hit;
            n = 0;
            hit = 1'b0;
            while (n < 200 && !hit) begin
                @(negedge clk);
                #2;
                hit = g_dut[0].ret_pending;
                n++;
            end
            if (!hit) fail_now("rdata_reset", "no read return seen within 200 cycles");
            @(posedge clk);
            #1 reset = 1'b1;
            repeat (2) @(posedge clk);
            #1 reset = 1'b0;
            repeat (60) @(posedge clk);
        end

        repeat (200) @(posedge clk);

        load_pct  = 0;
        stall_pct = 0;
        repeat (30) @(posedge clk);
        draining = 1'b1;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
